// File: rtl/chipi_link_pkg.sv
// chipi host link shared definitions.
// FSM state encoding and counter width helper.
package chipi_link_pkg;

    localparam int FRAME_W = 32;
    localparam int RES_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT,
        RECV,
        DONE
    } link_state_t;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/link_shift_reg.sv
// Generic left-shift register with parallel load.
// Load wins over shift; MSB is the serial output side.
module link_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift_en,
    input  logic         ser_in,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {q[W-2:0], ser_in};
        end
    end

endmodule

// File: rtl/chipi_host_link.sv
// Host-side chipi link: serialises {x1,x2} into chipi's SIPO,
// waits for ready, then deserialises the 16-bit result.
module chipi_host_link
    import chipi_link_pkg::*;
#(
    parameter int DATA_W   = RES_W,
    parameter int RX_DELAY = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_x1,
    input  logic [DATA_W-1:0] req_x2,
    input  logic              req_add_sub,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              chip_serial_in,
    output logic              chip_sipo_enable,
    output logic              chip_add_sub,
    input  logic              chip_ready,
    input  logic              chip_serial_out
);

    localparam int FW     = 2 * DATA_W;
    localparam int RX_END = RX_DELAY + DATA_W;
    localparam int M1     = (TIMEOUT > RX_END) ? TIMEOUT : RX_END;
    localparam int CNT_MAX = (M1 > FW) ? M1 : FW;
    localparam int CW     = cnt_w(CNT_MAX);

    link_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          add_sub_q;
    logic          timeout_q;
    logic          ready_en_q;
    logic          accept;
    logic          tx_shift;
    logic          rx_shift;
    logic          timeout_set;
    logic [FW-1:0] tx_q;
    logic          unused_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            add_sub_q  <= 1'b0;
            timeout_q  <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
            if (accept) begin
                add_sub_q <= req_add_sub;
                timeout_q <= 1'b0;
            end else if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // One counter serves SHIFT bit index, WAIT timer and RECV offset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        tx_shift    = 1'b0;
        rx_shift    = 1'b0;
        timeout_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_en_q) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                tx_shift = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(FW - 1)) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (chip_ready) begin
                    cnt_d   = CW'(1);
                    state_d = RECV;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RECV: begin
                rx_shift = (cnt_q >= CW'(RX_DELAY));
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(RX_END - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    link_shift_reg #(.W(FW)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data ({req_x1, req_x2}),
        .shift_en  (tx_shift),
        .ser_in    (1'b0),
        .q         (tx_q)
    );

    // Cleared on accept so a timeout reports zero.
    link_shift_reg #(.W(DATA_W)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data ('0),
        .shift_en  (rx_shift),
        .ser_in    (chip_serial_out),
        .q         (rsp_y)
    );

    assign unused_tx        = ^tx_q[FW-2:0];
    assign req_ready        = ready_en_q && (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign rsp_valid        = (state_q == DONE);
    assign rsp_timeout      = timeout_q;
    assign chip_sipo_enable = (state_q == SHIFT);
    assign chip_serial_in   = chip_sipo_enable & tx_q[FW-1];
    assign chip_add_sub     = busy & add_sub_q;

endmodule
